// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - grid constants and food placer state type shared by the snake blocks
package snake_pkg;

  localparam int COORD_W       = 8;
  localparam int GRID_W_DEF    = 40;
  localparam int GRID_H_DEF    = 30;
  localparam int MAX_TRIES_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_WAIT_R,
    ST_SCAN,
    ST_SCAN_WAIT
  } food_state_t;

endpackage

// File: rtl/food_placer.sv
// rtl/food_placer.sv - random food placement with occupancy check, retry and raster-scan fallback
module food_placer
  import snake_pkg::*;
#(
  parameter int GRID_W    = GRID_W_DEF,
  parameter int GRID_H    = GRID_H_DEF,
  parameter int MAX_TRIES = MAX_TRIES_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               place_req,
  input  logic [COORD_W-1:0] rand_x,
  input  logic [COORD_W-1:0] rand_y,
  output logic               occ_rd_en,
  output logic [COORD_W-1:0] occ_x,
  output logic [COORD_W-1:0] occ_y,
  input  logic               occ_data,
  output logic [COORD_W-1:0] food_x,
  output logic [COORD_W-1:0] food_y,
  output logic               food_valid,
  output logic               busy,
  output logic               grid_full
);

  localparam logic [COORD_W-1:0] W_LIM   = COORD_W'(GRID_W);
  localparam logic [COORD_W-1:0] H_LIM   = COORD_W'(GRID_H);
  localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(GRID_H - 1);
  localparam logic [7:0]         TRY_MAX = 8'(MAX_TRIES);

  food_state_t        state;
  logic [COORD_W-1:0] cand_x, cand_y;
  logic [COORD_W-1:0] scan_x, scan_y;
  logic [7:0]         try_cnt;

  logic               rand_ok, cand_ok, scan_last;
  logic [7:0]         try_inc;
  logic [COORD_W-1:0] scan_nx, scan_ny;

  always_comb begin
    rand_ok   = (rand_x < W_LIM) && (rand_y < H_LIM);
    cand_ok   = (cand_x < W_LIM) && (cand_y < H_LIM);
    try_inc   = (try_cnt == TRY_MAX) ? try_cnt : try_cnt + 8'd1;
    scan_last = (scan_x == X_LAST) && (scan_y == Y_LAST);
    scan_nx   = (scan_x == X_LAST) ? '0 : scan_x + 1'b1;
    scan_ny   = (scan_x == X_LAST) ? scan_y + 1'b1 : scan_y;
  end

  // The random pair is captured on every edge that enters SAMPLE and the read is
  // launched from a register then, so the RAM answers while the FSM sits in WAIT_R.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cand_x     <= '0;
      cand_y     <= '0;
      scan_x     <= '0;
      scan_y     <= '0;
      try_cnt    <= '0;
      occ_rd_en  <= 1'b0;
      occ_x      <= '0;
      occ_y      <= '0;
      food_x     <= '0;
      food_y     <= '0;
      food_valid <= 1'b0;
      busy       <= 1'b0;
      grid_full  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (place_req) begin
            food_valid <= 1'b0;
            grid_full  <= 1'b0;
            try_cnt    <= '0;
            busy       <= 1'b1;
            cand_x     <= rand_x;
            cand_y     <= rand_y;
            occ_rd_en  <= rand_ok;
            if (rand_ok) begin
              occ_x <= rand_x;
              occ_y <= rand_y;
            end
            state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          try_cnt <= try_inc;
          if (cand_ok) begin
            occ_rd_en <= 1'b0;
            state     <= ST_WAIT_R;
          end else if (try_inc == TRY_MAX) begin
            scan_x    <= '0;
            scan_y    <= '0;
            occ_x     <= '0;
            occ_y     <= '0;
            occ_rd_en <= 1'b1;
            state     <= ST_SCAN;
          end else begin
            cand_x    <= rand_x;
            cand_y    <= rand_y;
            occ_rd_en <= rand_ok;
            if (rand_ok) begin
              occ_x <= rand_x;
              occ_y <= rand_y;
            end
          end
        end
        ST_WAIT_R: begin
          if (!occ_data) begin
            food_x     <= cand_x;
            food_y     <= cand_y;
            food_valid <= 1'b1;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end else if (try_cnt == TRY_MAX) begin
            scan_x    <= '0;
            scan_y    <= '0;
            occ_x     <= '0;
            occ_y     <= '0;
            occ_rd_en <= 1'b1;
            state     <= ST_SCAN;
          end else begin
            cand_x    <= rand_x;
            cand_y    <= rand_y;
            occ_rd_en <= rand_ok;
            if (rand_ok) begin
              occ_x <= rand_x;
              occ_y <= rand_y;
            end
            state <= ST_SAMPLE;
          end
        end
        ST_SCAN: begin
          occ_rd_en <= 1'b0;
          state     <= ST_SCAN_WAIT;
        end
        ST_SCAN_WAIT: begin
          if (!occ_data) begin
            food_x     <= scan_x;
            food_y     <= scan_y;
            food_valid <= 1'b1;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end else if (scan_last) begin
            grid_full <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            scan_x    <= scan_nx;
            scan_y    <= scan_ny;
            occ_x     <= scan_nx;
            occ_y     <= scan_ny;
            occ_rd_en <= 1'b1;
            state     <= ST_SCAN;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_food_placer.sv
// tb/tb_food_placer.sv - directed self-checking bench for food_placer (default and MAX_TRIES=4 instances)
module tb_food_placer;

  localparam int GW = 40;
  localparam int GH = 30;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rand_x = '0, rand_y = '0;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic       occ_data_a = 1'b0, occ_data_b = 1'b0;

  logic       rd_a, rd_b, fv_a, fv_b, busy_a, busy_b, full_a, full_b;
  logic [7:0] ox_a, oy_a, ox_b, oy_b, fx_a, fy_a, fx_b, fy_b;

  bit occ_map [0:GW*GH-1];

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  food_placer dut_a (
    .clock(clock), .reset(reset), .place_req(req_a), .rand_x(rand_x), .rand_y(rand_y),
    .occ_rd_en(rd_a), .occ_x(ox_a), .occ_y(oy_a), .occ_data(occ_data_a),
    .food_x(fx_a), .food_y(fy_a), .food_valid(fv_a), .busy(busy_a), .grid_full(full_a)
  );

  food_placer #(.MAX_TRIES(4)) dut_b (
    .clock(clock), .reset(reset), .place_req(req_b), .rand_x(rand_x), .rand_y(rand_y),
    .occ_rd_en(rd_b), .occ_x(ox_b), .occ_y(oy_b), .occ_data(occ_data_b),
    .food_x(fx_b), .food_y(fy_b), .food_valid(fv_b), .busy(busy_b), .grid_full(full_b)
  );

  // Occupancy RAM: registered read, data valid the cycle after the strobe.
  always @(posedge clock) begin
    if (rd_a && ox_a < GW && oy_a < GH) occ_data_a <= occ_map[int'(oy_a) * GW + int'(ox_a)];
    if (rd_b && ox_b < GW && oy_b < GH) occ_data_b <= occ_map[int'(oy_b) * GW + int'(ox_b)];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fill_map(input bit v);
    for (int i = 0; i < GW * GH; i++) occ_map[i] = v;
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  initial begin
    int n;
    fill_map(1'b0);

    // reset state
    #2;
    check("rst_rd_en", rd_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_food_valid", fv_a, 0);
    check("rst_grid_full", full_a, 0);
    check("rst_occ_xy", {ox_a, oy_a, fx_a, fy_a}, 0);
    cyc(2);
    reset = 1'b0;
    cyc(1);

    // first-try hit: request in cycle 0
    rand_x = 8'd5; rand_y = 8'd7; req_a = 1'b1;
    cyc(1); req_a = 1'b0;
    check("hit_c1_rd_en", rd_a, 1);
    check("hit_c1_occ_xy", {ox_a, oy_a}, {8'd5, 8'd7});
    check("hit_c1_busy", busy_a, 1);
    cyc(1);
    check("hit_c2_rd_en", rd_a, 0);
    check("hit_c2_busy", busy_a, 1);
    check("hit_c2_food_valid", fv_a, 0);
    cyc(1);
    check("hit_c3_food_valid", fv_a, 1);
    check("hit_c3_food", {fx_a, fy_a}, {8'd5, 8'd7});
    check("hit_c3_busy", busy_a, 0);

    // collision retry: (5,7) occupied, then (9,2)
    occ_map[7 * GW + 5] = 1'b1;
    cyc(1);
    req_a = 1'b1;
    cyc(1); req_a = 1'b0;
    check("col_c1_rd_en", rd_a, 1);
    check("col_c1_food_valid", fv_a, 0);
    cyc(1);
    rand_x = 8'd9; rand_y = 8'd2;
    check("col_c2_rd_en", rd_a, 0);
    cyc(1);
    check("col_c3_rd_en", rd_a, 1);
    check("col_c3_occ_xy", {ox_a, oy_a}, {8'd9, 8'd2});
    cyc(1);
    check("col_c4_food_valid", fv_a, 0);
    cyc(1);
    check("col_c5_food_valid", fv_a, 1);
    check("col_c5_food", {fx_a, fy_a}, {8'd9, 8'd2});

    // out-of-range guard, plus a request while busy in WAIT_R
    rand_x = 8'd40; rand_y = 8'd3; req_a = 1'b1;
    cyc(1); req_a = 1'b0;
    check("oor_c1_rd_en", rd_a, 0);
    check("oor_c1_busy", busy_a, 1);
    rand_x = 8'd6;
    cyc(1);
    check("oor_c2_rd_en", rd_a, 1);
    check("oor_c2_occ_xy", {ox_a, oy_a}, {8'd6, 8'd3});
    cyc(1);
    req_a = 1'b1;
    cyc(1); req_a = 1'b0;
    check("oor_c4_food", {fv_a, fx_a, fy_a}, {1'b1, 8'd6, 8'd3});
    check("oor_c4_busy", busy_a, 0);
    cyc(1);
    check("busy_req_ignored", busy_a, 0);

    // scan fallback on the MAX_TRIES=4 instance
    rand_x = 8'd5; rand_y = 8'd7;
    occ_map[0] = 1'b1; occ_map[1] = 1'b1; occ_map[2] = 1'b1;
    req_b = 1'b1;
    cyc(1); req_b = 1'b0;
    cyc(8);
    check("scan_c9_rd_en", rd_b, 1);
    check("scan_c9_occ_xy", {ox_b, oy_b}, {8'd0, 8'd0});
    cyc(6);
    check("scan_c15_occ_xy", {rd_b, ox_b, oy_b}, {1'b1, 8'd3, 8'd0});
    cyc(1);
    check("scan_c16_food_valid", fv_b, 0);
    cyc(1);
    check("scan_c17_food", {fv_b, fx_b, fy_b}, {1'b1, 8'd3, 8'd0});
    check("scan_c17_busy", busy_b, 0);

    // grid full on the default instance
    fill_map(1'b1);
    req_a = 1'b1;
    cyc(1); req_a = 1'b0;
    check("full_c1_food_valid", fv_a, 0);
    n = 1;
    while (busy_a && n < 3000) begin
      cyc(1);
      n++;
    end
    check("full_end_cycle", n, 2433);
    check("full_grid_full", full_a, 1);
    check("full_food_valid", fv_a, 0);
    check("full_busy", busy_a, 0);

    // reset asserted while the MAX_TRIES=4 instance scans cell (1,0)
    req_b = 1'b1;
    cyc(1); req_b = 1'b0;
    cyc(10);
    check("mid_c11_rd", {rd_b, ox_b, oy_b}, {1'b1, 8'd1, 8'd0});
    reset = 1'b1;
    #1;
    check("mid_rst_b", {rd_b, ox_b, oy_b, fx_b, fy_b, fv_b, busy_b, full_b}, 0);
    check("mid_rst_a", {rd_a, ox_a, oy_a, fx_a, fy_a, fv_a, busy_a, full_a}, 0);

    // request on the edge where reset is still high is ignored
    cyc(1);
    req_a = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    req_a = 1'b0;
    cyc(1);
    check("req_at_reset_busy", busy_a, 0);
    check("req_at_reset_rd", rd_a, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
